count_checker: RTL
==================

COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 Parameter WIDTH, default 4, width of the monitored count value.
REQ-002 Parameter ECW, default 8, width of the error and wrap statistic counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 cnt_vld  input  1  high when the monitored counter is out of reset and cnt_in is meaningful.
REQ-006 cnt_in  input  WIDTH  monitored count value, sampled every rising edge.
REQ-007 locked  output  1  high while the checker is tracking a verified increment sequence.
REQ-008 expected  output  WIDTH  value the checker expects on the next sample; meaningful only while locked.
REQ-009 err_pulse  output  1  one-cycle pulse per detected sequence error.
REQ-010 err_cnt  output  ECW  saturating count of sequence errors since reset.
REQ-011 wrap_pulse  output  1  one-cycle pulse per verified wrap from all-ones to zero.
REQ-012 wrap_cnt  output  ECW  saturating count of verified wraps since reset.

Function
REQ-013 The block SHALL implement three states: IDLE, ACQ, LOCK; all outputs registered.
REQ-014 IDLE: on a sample with cnt_vld=1, capture cnt_in into prev and go to ACQ; otherwise stay.
REQ-015 ACQ: on a sample with cnt_vld=1 and cnt_in == prev+1 (mod 2^WIDTH), go to LOCK and set expected = cnt_in+1.
REQ-016 ACQ: on a sample with cnt_vld=1 and cnt_in != prev+1, recapture prev = cnt_in, stay in ACQ, no error flagged.
REQ-017 LOCK: on a sample with cnt_vld=1 and cnt_in == expected, stay; expected <= expected+1 (mod 2^WIDTH).
REQ-018 LOCK: on a sample with cnt_vld=1 and cnt_in != expected, assert err_pulse next cycle, increment err_cnt, capture prev = cnt_in, go to ACQ.
REQ-019 Any state: a sample with cnt_vld=0 SHALL go to IDLE with no error; cnt_vld dropping is a legal monitored-counter reset.
REQ-020 Wrap: in LOCK, an accepted sample of 0 when expected == 0 (previous value all-ones) SHALL pulse wrap_pulse next cycle and increment wrap_cnt.
REQ-021 The ACQ-to-LOCK transition SHALL count as a wrap if its accepted pair is all-ones followed by zero.
REQ-022 locked = 1 exactly while state is LOCK; it rises the cycle after the second consecutive incrementing sample.
REQ-023 err_pulse and wrap_pulse SHALL never be high in the same cycle and SHALL be low for every cycle not named in REQ-018/020/021.
REQ-024 err_cnt and wrap_cnt SHALL saturate at 2^ECW-1 and never roll over; pulses still fire at saturation.
REQ-025 Latency: every output reflects the sample taken on the previous rising edge (1 cycle).

Reset
REQ-026 With rst=1 on a rising edge: state = IDLE, locked = 0, expected = 0, err_pulse = 0, err_cnt = 0, wrap_pulse = 0, wrap_cnt = 0, prev = 0.
REQ-027 rst SHALL take priority over all inputs, including mid-LOCK, and clear the statistics.
REQ-028 The first cycle after rst falls SHALL be treated as IDLE regardless of cnt_vld.

Verification
REQ-029 Lock: reset 2 cycles, then cnt_vld=1 with cnt_in 0,1,2,3 on successive cycles -> locked rises after the sample 1, expected = 4 after sample 3, err_cnt = 0.
REQ-030 Wrap: locked sequence ..., E, F, 0, 1 -> exactly one wrap_pulse, the cycle after the sample 0; wrap_cnt = 1; locked stays 1.
REQ-031 Error: locked at expected 6, drive 9 -> err_pulse for one cycle, err_cnt = 1, locked = 0; then 10, 11 -> relock, expected = 12.
REQ-032 Monitored reset: locked at 5, drop cnt_vld for 3 cycles, then 0,1 -> no err_pulse, locked after sample 1.
REQ-033 Saturation (ECW=2): force 5 mismatches -> err_cnt stops at 3, five err_pulses seen.
REQ-034 Reset mid-operation: locked with err_cnt = 2, wrap_cnt = 1, assert rst for 1 cycle -> all outputs at REQ-026 values the next cycle.

Source files
------------

// File: rtl/count_checker.sv
// count_checker: watches a free-running counter and verifies it increments by one.
// Tracks lock, flags sequence errors and all-ones-to-zero wraps, and keeps saturating counts of each.
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   cnt_vld    : monitored counter is running and cnt_in is meaningful
//   cnt_in     : monitored count value, sampled every rising edge
//   locked     : high while tracking a verified increment sequence
//   expected   : next value the checker expects (meaningful while locked)
//   err_pulse  : one-cycle pulse per detected sequence error
//   err_cnt    : saturating count of sequence errors
//   wrap_pulse : one-cycle pulse per verified all-ones to zero wrap
//   wrap_cnt   : saturating count of verified wraps
module count_checker #(
    parameter int WIDTH = 4,
    parameter int ECW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_vld,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             err_pulse,
    output logic [ECW-1:0]   err_cnt,
    output logic             wrap_pulse,
    output logic [ECW-1:0]   wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [ECW-1:0]   SAT  = {ECW{1'b1}};

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_nx;
    logic [WIDTH-1:0] exp_nx;
    logic             err_nx;
    logic             wrap_nx;

    // Next-state and next-output decode for one sample
    always_comb begin
        state_nx = state;
        prev_nx  = prev;
        exp_nx   = expected;
        err_nx   = 1'b0;
        wrap_nx  = 1'b0;
        if (!cnt_vld) begin
            // Monitored counter in reset: legal, never an error
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    prev_nx  = cnt_in;
                    state_nx = ACQ;
                end
                ACQ: begin
                    if (cnt_in == prev + ONE) begin
                        state_nx = LOCK;
                        exp_nx   = cnt_in + ONE;
                        // Acquiring pair F,0 is itself a verified wrap
                        wrap_nx  = (prev == ALL1);
                    end else begin
                        prev_nx = cnt_in;
                    end
                end
                LOCK: begin
                    if (cnt_in == expected) begin
                        exp_nx  = expected + ONE;
                        wrap_nx = (expected == ZERO);
                    end else begin
                        err_nx   = 1'b1;
                        prev_nx  = cnt_in;
                        state_nx = ACQ;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prev  <= '0;
        end else begin
            state <= state_nx;
            prev  <= prev_nx;
        end
    end

    // Registered outputs and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            locked     <= 1'b0;
            expected   <= '0;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            locked     <= (state_nx == LOCK);
            expected   <= exp_nx;
            err_pulse  <= err_nx;
            wrap_pulse <= wrap_nx;
            if (err_nx && (err_cnt != SAT)) begin
                err_cnt <= err_cnt + ECW'(1);
            end
            if (wrap_nx && (wrap_cnt != SAT)) begin
                wrap_cnt <= wrap_cnt + ECW'(1);
            end
        end
    end

endmodule
